// File: rtl/riscv_pkg.sv
// Shared types for the commit trace path: FSM states, the buffered record and header layout.
// The record carries store address/data only when TRACE_MEM_EN is defined.
package riscv_pkg;

  localparam int TRACE_XLEN          = 32;
  localparam int TRACE_SEQ_W         = 16;
  localparam int TRACE_HDR_SEQ_LSB   = 16;
  localparam int TRACE_HDR_MEMWR_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    W_PC,
    W_INSTR,
    W_HDR,
    W_DATA,
    W_MADDR,
    W_MDATA
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic [TRACE_XLEN-1:0]  pc;
    logic [TRACE_XLEN-1:0]  instr;
    logic [4:0]             regAddr;
    logic [TRACE_XLEN-1:0]  regData;
    logic                   memWr;
`ifdef TRACE_MEM_EN
    logic [TRACE_XLEN-1:0]  memAddr;
    logic [TRACE_XLEN-1:0]  memData;
`endif
  } trace_rec_t;

  // Header word: sequence number on top, store flag, then the destination register.
  function automatic logic [TRACE_XLEN-1:0] traceHeader(input trace_rec_t rec);
    logic [TRACE_XLEN-1:0] hdr;
    hdr = '0;
    hdr[TRACE_HDR_SEQ_LSB +: TRACE_SEQ_W] = rec.seq;
    hdr[TRACE_HDR_MEMWR_BIT]              = rec.memWr;
    hdr[4:0]                              = rec.regAddr;
    return hdr;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with occupancy count; a push is accepted while full
// provided a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  // NOTE: storage is not reset; pointers and count define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  assign rdData = mem[rdPtr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures one record per retired instruction and streams it as words
// PC, INSTR, HDR, DATA over valid/ready. Define TRACE_MEM_EN to append MADDR, MDATA for stores.
module commit_trace_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN  = TRACE_XLEN,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     retire_valid_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic                     mem_wr_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  output logic                     tr_valid_o,
  input  logic                     tr_ready_i,
  output logic [XLEN-1:0]          tr_data_o,
  output logic                     tr_last_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_state_e           state;
  trace_state_e           afterLast;
  trace_rec_t             wrRec;
  trace_rec_t             headRec;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic                   handshake;
  logic                   lastWord;
  logic                   isStoreRec;
  logic                   popNow;
  logic                   pushNow;
  logic                   dropNow;
  logic [CW-1:0]          nextCount;
  logic [TRACE_SEQ_W-1:0] seq;

`ifdef TRACE_MEM_EN
  assign isStoreRec = headRec.memWr;
`else
  logic unusedStore;
  assign unusedStore = ^{mem_addr_i, mem_data_i};
  assign isStoreRec  = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wrRec         = '0;
    wrRec.seq     = seq;
    wrRec.pc      = pc_i;
    wrRec.instr   = instr_i;
    wrRec.regAddr = reg_addr_i;
    wrRec.regData = reg_data_i;
    wrRec.memWr   = mem_wr_i;
`ifdef TRACE_MEM_EN
    wrRec.memAddr = mem_addr_i;
    wrRec.memData = mem_data_i;
`endif
  end

  assign tr_valid_o = (state != IDLE);
  assign handshake  = tr_valid_o && tr_ready_i;
  assign lastWord   = (state == W_MDATA) || ((state == W_DATA) && !isStoreRec);
  assign tr_last_o  = lastWord;

  // A full FIFO still takes a record when the head leaves on this very edge.
  assign popNow    = handshake && lastWord;
  assign pushNow   = retire_valid_i && (!fifoFull || popNow);
  assign dropNow   = retire_valid_i && fifoFull && !popNow;
  assign nextCount = count_o - CW'(popNow) + CW'(pushNow);
  assign afterLast = (nextCount != '0) ? W_PC : IDLE;

  trace_fifo #(
    .WIDTH ($bits(trace_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (pushNow),
    .wrData (wrRec),
    .pop    (popNow),
    .rdData (headRec),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (count_o)
  );

  always_comb begin
    tr_data_o = '0;
    case (state)
      W_PC:    tr_data_o = headRec.pc;
      W_INSTR: tr_data_o = headRec.instr;
      W_HDR:   tr_data_o = traceHeader(headRec);
      W_DATA:  tr_data_o = headRec.regData;
`ifdef TRACE_MEM_EN
      W_MADDR: tr_data_o = headRec.memAddr;
      W_MDATA: tr_data_o = headRec.memData;
`endif
      default: tr_data_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      seq        <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (pushNow) seq <= seq + 1'b1;
      if (dropNow) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
      case (state)
        IDLE:    if (!fifoEmpty) state <= W_PC;
        W_PC:    if (handshake)  state <= W_INSTR;
        W_INSTR: if (handshake)  state <= W_HDR;
        W_HDR:   if (handshake)  state <= W_DATA;
        W_DATA:  if (handshake)  state <= isStoreRec ? W_MADDR : afterLast;
        W_MADDR: if (handshake)  state <= W_MDATA;
        W_MDATA: if (handshake)  state <= afterLast;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: a per-cycle vector table plus hand-written
// sequences for overflow, full-with-pop, stores (TRACE_MEM_EN aware) and mid-record reset.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        retireValid;
  logic [31:0] pcIn;
  logic [31:0] instrIn;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        memWr;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        trValid;
  logic        trReady;
  logic [31:0] trData;
  logic        trLast;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] dropCnt;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        ret;
    logic        rdy;
    logic        expValid;
    logic [31:0] expData;
    logic        expLast;
    logic [3:0]  expCount;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  commit_trace_buffer #(.XLEN(32), .DEPTH(8), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .retire_valid_i (retireValid),
    .pc_i           (pcIn),
    .instr_i        (instrIn),
    .reg_addr_i     (regAddr),
    .reg_data_i     (regData),
    .mem_wr_i       (memWr),
    .mem_addr_i     (memAddr),
    .mem_data_i     (memData),
    .tr_valid_o     (trValid),
    .tr_ready_i     (trReady),
    .tr_data_o      (trData),
    .tr_last_o      (trLast),
    .count_o        (count),
    .overflow_o     (overflow),
    .drop_cnt_o     (dropCnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    retireValid = 1'b0;
    trReady = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic addVec(input logic r, input logic y, input logic v, input logic [31:0] d,
                        input logic l, input logic [3:0] c);
    vec_t t;
    t.ret = r; t.rdy = y; t.expValid = v; t.expData = d; t.expLast = l; t.expCount = c;
    vecs.push_back(t);
  endtask

  function automatic logic [31:0] genPc(input int s);
    return 32'h0000_1000 + 32'(s * 4);
  endfunction

  function automatic logic [31:0] genInstr(input int s);
    return 32'h0000_0013 + 32'(s << 7);
  endfunction

  function automatic logic [4:0] genRd(input int s);
    return 5'((s + 1) % 32);
  endfunction

  function automatic logic [31:0] genData(input int s);
    return 32'hA5A5_0000 + 32'(s);
  endfunction

  function automatic logic [31:0] hdrWord(input logic [15:0] sq, input logic mw, input logic [4:0] rd);
    return {sq, 8'h00, mw, 2'b00, rd};
  endfunction

  task automatic driveRec(input int s);
    retireValid = 1'b1;
    pcIn = genPc(s);
    instrIn = genInstr(s);
    regAddr = genRd(s);
    regData = genData(s);
    memWr = 1'b0;
    memAddr = 32'h0;
    memData = 32'h0;
  endtask

  // Expects ready=1 and the first record's PC word on the bus; checks n non-store records.
  task automatic drainCheck(input int first, input int n, input int seqBase);
    logic [31:0] words [4];
    for (int r = 0; r < n; r++) begin
      words[0] = genPc(first + r);
      words[1] = genInstr(first + r);
      words[2] = hdrWord(16'(seqBase + r), 1'b0, genRd(first + r));
      words[3] = genData(first + r);
      for (int w = 0; w < 4; w++) begin
        check($sformatf("drain rec%0d w%0d valid", first + r, w), 32'(trValid), 32'h1);
        check($sformatf("drain rec%0d w%0d data", first + r, w), trData, words[w]);
        check($sformatf("drain rec%0d w%0d last", first + r, w), 32'(trLast), 32'(w == 3));
        tick();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp5[$];

    rst = 1'b1; retireValid = 1'b0; trReady = 1'b0;
    pcIn = '0; instrIn = '0; regAddr = '0; regData = '0;
    memWr = 1'b0; memAddr = '0; memData = '0;

    // Reset state
    doReset();
    check("reset valid", 32'(trValid), 32'h0);
    check("reset last", 32'(trLast), 32'h0);
    check("reset data", trData, 32'h0);
    check("reset count", 32'(count), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset dropcnt", 32'(dropCnt), 32'h0);

    // Single record without and with backpressure on INSTR (seq 0 then seq 1)
    pcIn = 32'h8000_0000; instrIn = 32'h0050_0093; regAddr = 5'd1; regData = 32'h5;
    addVec(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 4'd1);
    addVec(1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 4'd1);
    addVec(1'b0, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 4'd1);
    addVec(1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 4'd1);
    addVec(1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 4'd1);
    addVec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 4'd0);
    addVec(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 4'd1);
    addVec(1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 4'd1);
    addVec(1'b0, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 4'd1);
    addVec(1'b0, 1'b0, 1'b1, 32'h0050_0093, 1'b0, 4'd1);
    addVec(1'b0, 1'b0, 1'b1, 32'h0050_0093, 1'b0, 4'd1);
    addVec(1'b0, 1'b0, 1'b1, 32'h0050_0093, 1'b0, 4'd1);
    addVec(1'b0, 1'b1, 1'b1, 32'h0001_0001, 1'b0, 4'd1);
    addVec(1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 4'd1);
    addVec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 4'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      retireValid = vecs[i].ret;
      trReady = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d valid", i), 32'(trValid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) check($sformatf("vec%0d data", i), trData, vecs[i].expData);
      check($sformatf("vec%0d last", i), 32'(trLast), 32'(vecs[i].expLast));
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].expCount));
    end
    retireValid = 1'b0;

    // Overflow: 10 retires into 8 entries with the sink stalled
    doReset();
    for (int i = 0; i < 10; i++) begin
      driveRec(i);
      tick();
    end
    retireValid = 1'b0;
    check("ovf count", 32'(count), 32'd8);
    check("ovf dropcnt", 32'(dropCnt), 32'd2);
    check("ovf sticky", 32'(overflow), 32'h1);
    trReady = 1'b1;
    drainCheck(0, 8, 0);
    check("ovf drained valid", 32'(trValid), 32'h0);
    check("ovf drained count", 32'(count), 32'h0);
    check("ovf sticky after drain", 32'(overflow), 32'h1);
    driveRec(30);
    tick();
    retireValid = 1'b0;
    tick();
    drainCheck(30, 1, 8);

    // Full FIFO, retire coincides with the last-word handshake
    doReset();
    for (int i = 0; i < 8; i++) begin
      driveRec(i);
      tick();
    end
    retireValid = 1'b0;
    check("full count", 32'(count), 32'd8);
    trReady = 1'b1;
    check("full w0", trData, genPc(0));
    tick();
    check("full w1", trData, genInstr(0));
    tick();
    check("full w2", trData, hdrWord(16'd0, 1'b0, genRd(0)));
    tick();
    check("full w3", trData, genData(0));
    check("full w3 last", 32'(trLast), 32'h1);
    driveRec(8);
    tick();
    retireValid = 1'b0;
    check("pushpop count", 32'(count), 32'd8);
    check("pushpop dropcnt", 32'(dropCnt), 32'h0);
    check("pushpop overflow", 32'(overflow), 32'h0);
    drainCheck(1, 8, 1);
    check("pushpop drained valid", 32'(trValid), 32'h0);

    // Store record
    doReset();
    trReady = 1'b1;
    retireValid = 1'b1;
    pcIn = 32'h0000_0200; instrIn = 32'h00A1_2023; regAddr = 5'd0; regData = 32'h0;
    memWr = 1'b1; memAddr = 32'h0000_0100; memData = 32'hDEAD_BEEF;
    tick();
    retireValid = 1'b0; memWr = 1'b0;
    check("store queued count", 32'(count), 32'd1);
    tick();
    exp5 = {32'h0000_0200, 32'h00A1_2023, 32'h0000_0080, 32'h0000_0000};
`ifdef TRACE_MEM_EN
    exp5.push_back(32'h0000_0100);
    exp5.push_back(32'hDEAD_BEEF);
`endif
    for (int w = 0; w < exp5.size(); w++) begin
      check($sformatf("store w%0d valid", w), 32'(trValid), 32'h1);
      check($sformatf("store w%0d data", w), trData, exp5[w]);
      check($sformatf("store w%0d last", w), 32'(trLast), 32'(w == exp5.size() - 1));
      tick();
    end
    check("store done valid", 32'(trValid), 32'h0);

    // Reset while the header word is on the bus
    driveRec(20);
    tick();
    retireValid = 1'b0;
    tick();
    tick();
    tick();
    check("pre-reset hdr", trData, hdrWord(16'd1, 1'b0, genRd(20)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst valid", 32'(trValid), 32'h0);
    check("midrst count", 32'(count), 32'h0);
    check("midrst last", 32'(trLast), 32'h0);
    driveRec(21);
    tick();
    retireValid = 1'b0;
    tick();
    drainCheck(21, 1, 0);
    check("post-reset idle", 32'(trValid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
